// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold generation, exception flush/redirect,
// stall watchdog and a saturating stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned  STALL_TIMEOUT = 200,
  parameter logic [31:0]  EXC_VECTOR    = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  input  logic        cnt_clear_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [31:0] EXC_ERET    = 32'h0000000e;
  localparam logic [7:0]  TIMEOUT_LIM = 8'(STALL_TIMEOUT);

  state_t      state_r;
  logic [7:0]  wd_r;
  logic [31:0] stall_cnt_r;
  logic        timeout_r;

  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;
  logic        exc_s;

  assign exc_s = (excepttype_i != 32'h00000000);

  // Hold/flush decode; in FLUSH the id/ex/mem requests are stale, only fetch is honored.
  always_comb begin
    stall_s  = 6'b000000;
    flush_s  = 1'b0;
    new_pc_s = 32'h00000000;
    if (!rst) begin
      stall_s  = 6'b000000;
      flush_s  = 1'b0;
      new_pc_s = 32'h00000000;
    end else if (exc_s) begin
      flush_s = 1'b1;
      if (excepttype_i == EXC_ERET) begin
        new_pc_s = epc_i;
      end else begin
        new_pc_s = EXC_VECTOR;
      end
    end else begin
      case (state_r)
        ST_FLUSH: begin
          if (stallreq_from_if) begin
            stall_s = 6'b000011;
          end else begin
            stall_s = 6'b000000;
          end
        end
        ST_RUN, ST_STALL: begin
          if (stallreq_from_mem) begin
            stall_s = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall_s = 6'b001111;
          end else if (stallreq_from_id) begin
            stall_s = 6'b000111;
          end else if (stallreq_from_if) begin
            stall_s = 6'b000011;
          end else begin
            stall_s = 6'b000000;
          end
        end
        default: stall_s = 6'b000000;
      endcase
    end
  end

  // FSM, watchdog, sticky timeout and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      wd_r        <= 8'd0;
      stall_cnt_r <= 32'h00000000;
      timeout_r   <= 1'b0;
    end else begin
      if (flush_s) begin
        state_r <= ST_FLUSH;
      end else if (stall_s != 6'b000000) begin
        state_r <= ST_STALL;
      end else begin
        state_r <= ST_RUN;
      end

      if (flush_s || (stall_s == 6'b000000)) begin
        wd_r <= 8'd0;
      end else if (wd_r != 8'hFF) begin
        wd_r <= wd_r + 8'd1;
      end

      if (wd_r >= TIMEOUT_LIM) begin
        timeout_r <= 1'b1;
      end

      // Clear has priority over a coincident stalled cycle.
      if (cnt_clear_i) begin
        stall_cnt_r <= 32'h00000000;
      end else if ((stall_s != 6'b000000) && (stall_cnt_r != 32'hFFFFFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign stall       = stall_s;
  assign flush       = flush_s;
  assign new_pc      = new_pc_s;
  assign stall_cnt_o = stall_cnt_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes expected outputs from a behavioural
// model, an independent monitor pops and compares them on every falling edge.
module tb_pipe_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] excepttype, epc;
  logic        cnt_clear;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  exp_t q[$];

  // Model state: was the previous cycle a flush, length of current stall streak,
  // performance counter and sticky timeout as they stand before the next edge.
  bit          m_flush_prev;
  int          m_streak;
  logic [31:0] m_cnt;
  bit          m_to;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(TO), .EXC_VECTOR(32'h00000020)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (excepttype),
    .epc_i             (epc),
    .cnt_clear_i       (cnt_clear),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cnt_o       (stall_cnt),
    .timeout_o         (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: apply inputs after the edge, push expectation, advance model.
  task automatic cycle(input bit r, input bit fi, input bit di, input bit ei, input bit mi,
                       input logic [31:0] exc, input logic [31:0] pc_in, input bit clr,
                       input bit preload);
    exp_t        e;
    int          n;
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    @(posedge clk);
    #1;
    if (preload) begin
      force dut.stall_cnt_r = 32'hFFFFFFFE;
      #1;
      release dut.stall_cnt_r;
      m_cnt = 32'hFFFFFFFE;
    end
    rst = r; req_if = fi; req_id = di; req_ex = ei; req_mem = mi;
    excepttype = exc; epc = pc_in; cnt_clear = clr;

    s = 6'd0; f = 1'b0; pc = 32'd0;
    if (r) begin
      if (exc != 32'd0) begin
        f  = 1'b1;
        pc = (exc == 32'h0000000e) ? pc_in : 32'h00000020;
      end else begin
        if (m_flush_prev) n = fi ? 2 : 0;
        else n = mi ? 5 : ei ? 4 : di ? 3 : fi ? 2 : 0;
        s = 6'((1 << n) - 1);
      end
    end
    e.stall = s; e.flush = f; e.new_pc = pc; e.cnt = m_cnt; e.to = m_to;
    q.push_back(e);

    if (!r) begin
      m_flush_prev = 1'b0; m_streak = 0; m_cnt = 32'd0; m_to = 1'b0;
    end else begin
      if (m_streak >= int'(TO)) m_to = 1'b1;
      if (f || s == 6'd0) m_streak = 0;
      else if (m_streak < 255) m_streak = m_streak + 1;
      if (clr) m_cnt = 32'd0;
      else if (s != 6'd0 && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
      m_flush_prev = f;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
  endtask

  // Monitor: every cycle is an output beat; compare the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",     32'(stall),   32'(e.stall));
        chk("flush",     32'(flush),   32'(e.flush));
        chk("new_pc",    new_pc,       e.new_pc);
        chk("stall_cnt", stall_cnt,    e.cnt);
        chk("timeout",   32'(timeout), 32'(e.to));
      end
    end
  end

  initial begin : driver
    int          w;
    bit          r, clr;
    logic [31:0] exc;
    rst = 1'b0; req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    excepttype = 32'd0; epc = 32'd0; cnt_clear = 1'b0;
    m_flush_prev = 1'b0; m_streak = 0; m_cnt = 32'd0; m_to = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with requests and an exception present to show they are masked.
    cycle(0, 1, 1, 1, 1, 32'h1, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

    // id + mem held three cycles, then released.
    repeat (3) cycle(1, 0, 1, 0, 1, 32'd0, 32'd0, 0, 0);
    idle(2);

    // Exception with ex request; following FLUSH cycle ignores ex.
    cycle(1, 0, 0, 1, 0, 32'h1, 32'h0, 0, 0);
    cycle(1, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    cycle(1, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
    idle(1);

    // eret redirects to EPC, then back to RUN.
    cycle(1, 0, 0, 0, 0, 32'he, 32'h00400100, 0, 0);
    cycle(1, 0, 1, 0, 0, 32'h0, 32'h00400100, 0, 0);
    cycle(1, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0);
    // FLUSH still honors fetch request; back-to-back exception restarts FLUSH.
    cycle(1, 0, 0, 0, 0, 32'h5, 32'h0, 0, 0);
    cycle(1, 0, 0, 0, 0, 32'he, 32'h1234, 0, 0);
    cycle(1, 1, 1, 1, 1, 32'h0, 32'h0, 0, 0);
    idle(1);

    // Watchdog: ex held six cycles with a limit of four; timeout is sticky.
    cycle(0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    repeat (6) cycle(1, 0, 0, 1, 0, 32'd0, 32'd0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    idle(1);

    // Counter saturation from a preloaded value, then clear during a stall.
    cycle(1, 0, 0, 1, 0, 32'd0, 32'd0, 0, 1);
    repeat (2) cycle(1, 0, 0, 1, 0, 32'd0, 32'd0, 0, 0);
    cycle(1, 0, 0, 1, 0, 32'd0, 32'd0, 1, 0);
    idle(2);

    // Reset during a stall with fetch request held through the release.
    repeat (2) cycle(1, 1, 0, 1, 0, 32'd0, 32'd0, 0, 0);
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    // Reset during FLUSH.
    cycle(1, 0, 0, 0, 0, 32'h3, 32'd0, 0, 0);
    cycle(0, 0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    cycle(1, 0, 1, 0, 0, 32'd0, 32'd0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 99) != 0);
      clr = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 19))
        0:       exc = 32'h0000000e;
        1:       exc = 32'h00000001;
        2:       exc = $urandom() | 32'h00000100;
        default: exc = 32'd0;
      endcase
      cycle(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            exc, $urandom(), clr, 0);
    end

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
